// File: rtl/nano_dmem.sv
`default_nettype none
// ============================================================================
// Module   : nano_dmem
// Purpose  : Word-organised data memory for the nano_rv32i d-bus with byte-lane
//            stores and one-cycle registered reads. Optional bounds checking is
//            enabled with `define DMEM_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nano_dmem #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    input  logic [3:0]  d_we_i,
    output logic [31:0] d_data_o,
    output logic        d_valid_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];

    logic [31:0]   d_data_q, d_data_d;
    logic          rd_pending_q, rd_pending_d;

    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_boff;
    logic          w_wr_req;
    logic [3:0]    w_lane_en;
    logic [31:0]   w_wdata;
    logic          w_rd_en;
    logic          w_wr_en;
    logic          w_oob;
    logic          w_unused;

    assign w_offset  = d_addr_i - BASE_ADDR;
    assign w_idx     = w_offset[AW+1:2];
    assign w_boff    = d_addr_i[1:0];
    assign w_wr_req  = d_wr_i | (|d_we_i);
    assign w_lane_en = (d_we_i == 4'h0) ? 4'hF : d_we_i;
    assign w_wdata   = d_data_i << {w_boff, 3'b000};
    // Writes win over reads so a same-cycle read never sees a half-updated word.
    assign w_rd_en   = d_rd_i & ~w_wr_req;

`ifdef DMEM_BOUNDS_CHECK_EN
    logic       err_q, err_d;
    logic [2:0] w_span;
    logic       w_cross;

    assign w_oob    = ({2'b00, w_offset[31:2]} >= 32'(DEPTH));
    assign w_span   = {2'b00, w_lane_en[0]} + {2'b00, w_lane_en[1]}
                    + {2'b00, w_lane_en[2]} + {2'b00, w_lane_en[3]};
    assign w_cross  = ({1'b0, w_boff} + w_span) > 3'd4;
    assign w_unused = ^w_offset[1:0];

    always_comb begin
        err_d = err_q;
        if ((w_wr_req & (w_oob | w_cross)) | (w_rd_en & w_oob)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // Without checking, the index simply wraps onto the low address bits.
    assign w_oob    = 1'b0;
    assign w_unused = ^{w_offset[31:AW+2], w_offset[1:0]};
    assign err_o    = 1'b0;
`endif

    // Gating with rst_n_i drops a store sampled on the same edge reset asserts.
    assign w_wr_en = w_wr_req & rst_n_i & ~w_oob;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lane_en[k]) begin
                    mem_q[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        d_data_d     = d_data_q;
        rd_pending_d = w_rd_en;
        if (w_rd_en) begin
            d_data_d = w_oob ? 32'hDEAD_BEEF : mem_q[w_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            d_data_q     <= 32'h0;
            rd_pending_q <= 1'b0;
        end else begin
            d_data_q     <= d_data_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign d_data_o  = d_data_q;
    assign d_valid_o = rd_pending_q;

endmodule
`default_nettype wire
